// File: rtl/spi_controller.sv
// spi_controller: SPI initiator issuing one 16-bit {rw, addr, data} register frame per start.
// Every output is a register; ena low freezes the divider, FSM and outputs.
module spi_controller #(
   parameter int CLK_DIV    = 4,
   parameter int REG_WIDTH  = 8,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [1:0]            mode,
   input  logic                  start,
   input  logic                  rw,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [REG_WIDTH-1:0]  wdata,
   output logic                  busy,
   output logic                  done,
   output logic [REG_WIDTH-1:0]  rdata,
   output logic                  spi_cs_n,
   output logic                  spi_clk,
   output logic                  spi_mosi,
   input  logic                  spi_miso
);
   localparam int FW = 1 + ADDR_WIDTH + REG_WIDTH;
   localparam int NE = 2 * FW;
   localparam int DW = $clog2(CLK_DIV);
   localparam int EW = $clog2(NE);

   if (CLK_DIV < 4) begin : g_bad_div
      $error("CLK_DIV must be at least 4");
   end
   if (1 + ADDR_WIDTH != 8) begin : g_bad_addr
      $error("1 + ADDR_WIDTH must equal 8");
   end

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_e;

   state_e               state_q, state_d;
   logic [DW-1:0]        div_q, div_d;
   logic [EW-1:0]        ecnt_q, ecnt_d;
   logic [FW-1:0]        tx_q, tx_d;
   logic [REG_WIDTH-1:0] rx_q, rx_d, rdata_q, rdata_d;
   logic                 cpol_q, cpol_d, cpha_q, cpha_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic                 cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d;
   logic                 tick, lead, last;
   logic [FW-1:0]        frame;

   assign frame = {rw, addr, wdata};
   assign tick  = div_q == DW'(CLK_DIV - 1);
   assign lead  = ~ecnt_q[0];
   assign last  = ecnt_q == EW'(NE - 1);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      ecnt_d  = ecnt_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      busy_d  = busy_q;
      done_d  = done_q;
      cs_n_d  = cs_n_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      if (ena) begin
         done_d = 1'b0;
         div_d  = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
         case (state_q)
            IDLE: if (start) begin
               state_d          = SETUP;
               {cpol_d, cpha_d} = mode;
               busy_d           = 1'b1;
               cs_n_d           = 1'b0;
               sck_d            = mode[1];
               mosi_d           = ~mode[0] & frame[FW-1];
               tx_d             = mode[0] ? frame : frame << 1;
            end
            SETUP: if (tick) state_d = XFER;
            XFER: if (tick) begin
               sck_d  = ~sck_q;
               ecnt_d = last ? '0 : ecnt_q + 1'b1;
               // CPHA=0 bit 15 is already on MOSI, so only the trailing edges before the last one shift
               if (cpha_q ? lead : (~lead && ~last)) begin
                  mosi_d = tx_q[FW-1];
                  tx_d   = tx_q << 1;
               end
               if (lead ^ cpha_q) rx_d = {rx_q[REG_WIDTH-2:0], spi_miso};
               if (last) state_d = HOLD;
            end
            HOLD: if (tick) begin
               state_d = GAP;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               done_d  = 1'b1;
               rdata_d = rx_q;
            end
            GAP: if (tick) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         ecnt_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         ecnt_q  <= ecnt_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_n_q  <= cs_n_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rdata    = rdata_q;
   assign spi_cs_n = cs_n_q;
   assign spi_clk  = sck_q;
   assign spi_mosi = mosi_q;
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: drives spi_controller against a behavioural register-bank responder,
// scoreboarding the MOSI frame and rdata of each transaction.
module tb_spi_controller;
   localparam int CLK_DIV = 4;
   localparam logic [7:0] CMD_RESP = 8'h5A;

   typedef struct packed {
      logic [15:0] frame;
      logic [7:0]  rdata;
   } exp_t;

   logic       clk = 1'b0, rst = 1'b1, ena = 1'b1, start = 1'b0, rw = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [6:0] addr = '0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata;
   logic       busy, done, spi_cs_n, spi_clk, spi_mosi;
   logic       spi_miso = 1'b0;

   int checks = 0, failures = 0;
   int unsigned cyc = 0, t_start = 0, t_done = 0, t_idle = 0;
   exp_t sb[$];
   exp_t me;
   logic [7:0] mem [128];
   logic [7:0] shadow [128];

   logic [1:0]  r_mode = 2'b00;
   logic [15:0] rx = '0, last_frame = '0;
   logic [6:0]  ra = '0;
   logic        prev_cs = 1'b1, prev_sck = 1'b0;
   int          ecnt = 0, idx = 0, cs_low = 0, low_seen = 0, edges_seen = 0, ndone = 0;

   spi_controller #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .rst(rst), .ena(ena), .mode(mode), .start(start), .rw(rw),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
      .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic resp_bit(input int i);
      logic [7:0] b;
      b = (i < 8) ? CMD_RESP : mem[ra];
      return b[7 - (i % 8)];
   endfunction

   // Responder model plus done-side scoreboard, evaluated on the falling clk edge
   initial forever begin
      @(negedge clk);
      if (prev_cs && !spi_cs_n) begin
         ecnt   = 0;
         rx     = '0;
         cs_low = 0;
         spi_miso = r_mode[0] ? 1'b0 : resp_bit(0);
      end else if (!spi_cs_n && spi_clk != prev_sck) begin
         if (ecnt[0] == r_mode[0]) rx = {rx[14:0], spi_mosi};
         else begin
            idx = (ecnt + 1) / 2;
            if (idx == 8) ra = rx[6:0];
            if (idx < 16) spi_miso = resp_bit(idx);
         end
         ecnt++;
      end
      if (!spi_cs_n) cs_low++;
      if (!prev_cs && spi_cs_n) begin
         last_frame = rx;
         edges_seen = ecnt;
         low_seen   = cs_low;
         if (ecnt == 32 && rx[15]) mem[rx[14:8]] = rx[7:0];
         spi_miso = 1'b0;
      end
      if (done) begin
         ndone++;
         t_done = cyc;
         if (sb.size() == 0) chk("done_expected", 32'(sb.size()), 1);
         else begin
            me = sb.pop_front();
            chk("mosi_frame", 32'(last_frame), 32'(me.frame));
            chk("rdata", 32'(rdata), 32'(me.rdata));
            chk("sck_edges", edges_seen, 32);
         end
      end
      prev_cs  = spi_cs_n;
      prev_sck = spi_clk;
   end

   task automatic launch(input logic r, input logic [6:0] a, input logic [7:0] d, input logic [1:0] m);
      exp_t x;
      @(negedge clk);
      rw = r; addr = a; wdata = d; mode = m; r_mode = m; start = 1'b1;
      t_start = cyc;
      x.frame = {r, a, d};
      x.rdata = shadow[a];
      sb.push_back(x);
      if (r) shadow[a] = d;
      @(negedge clk);
      start = 1'b0;
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      t_idle = cyc;
      chk("idle_timeout", 32'(busy), 0);
   endtask

   task automatic wait_edge(input int k);
      int n = 0;
      @(negedge clk);
      #1;
      while (ecnt < k && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("reach_edge", 32'(ecnt >= k), 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n0, e0, changes;
      logic [12:0] snap;
      exp_t dropped;
      for (int i = 0; i < 128; i++) begin
         mem[i]    = '0;
         shadow[i] = '0;
      end
      mem[0]    = 8'hCA;
      shadow[0] = 8'hCA;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_cs_n", 32'(spi_cs_n), 1);
      chk("rst_sck", 32'(spi_clk), 0);
      chk("rst_mosi", 32'(spi_mosi), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rdata", 32'(rdata), 0);

      launch(1'b0, 7'h00, 8'h00, 2'b00);
      wait_idle(400);

      launch(1'b1, 7'h00, 8'hA5, 2'b00);
      wait_idle(400);
      chk("cs_low_cycles", low_seen, 136);
      chk("done_latency", t_done - t_start, 137);
      chk("busy_latency", t_idle - t_start, 141);

      for (int m = 0; m < 4; m++) begin
         launch(1'b1, 7'h00, 8'h3C, 2'(m));
         wait_idle(400);
         chk("sck_idle_w", 32'(spi_clk), 32'(m / 2));
         chk("resp_reg0", 32'(mem[0]), 32'h3C);
         launch(1'b0, 7'h00, 8'h00, 2'(m));
         wait_idle(400);
         chk("sck_idle_r", 32'(spi_clk), 32'(m / 2));
      end

      n0 = ndone;
      launch(1'b1, 7'h11, 8'h96, 2'b01);
      wait_edge(10);
      start = 1'b1; mode = 2'b10; addr = 7'h7F; rw = 1'b0; wdata = 8'h00;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_idle(400);
      chk("single_done", ndone - n0, 1);
      chk("resp_reg11", 32'(mem[7'h11]), 32'h96);

      launch(1'b0, 7'h05, 8'h00, 2'b10);
      wait_edge(20);
      n0 = ndone;
      rst = 1'b1;
      #1;
      chk("mid_rst_cs_n", 32'(spi_cs_n), 1);
      chk("mid_rst_sck", 32'(spi_clk), 0);
      chk("mid_rst_mosi", 32'(spi_mosi), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      dropped = sb.pop_back();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      chk("no_done_on_rst", ndone - n0, 0);
      chk("rdata_after_rst", 32'(rdata), 0);
      launch(1'b1, 7'h03, 8'h55, 2'b00);
      wait_idle(400);
      chk("resp_reg3", 32'(mem[3]), 32'h55);
      launch(1'b0, 7'h03, 8'h00, 2'b00);
      wait_idle(400);

      launch(1'b1, 7'h07, 8'hE1, 2'b11);
      wait_edge(12);
      ena = 1'b0;
      snap = {spi_cs_n, spi_clk, spi_mosi, busy, done, rdata};
      e0 = ecnt;
      changes = 0;
      repeat (50) begin
         @(negedge clk);
         #1;
         if ({spi_cs_n, spi_clk, spi_mosi, busy, done, rdata} !== snap) changes++;
      end
      ena = 1'b1;
      chk("stall_hold", changes, 0);
      chk("stall_no_sck", ecnt - e0, 0);
      wait_idle(500);
      chk("stall_done_latency", t_done - t_start, 187);
      launch(1'b0, 7'h07, 8'h00, 2'b11);
      wait_idle(400);

      chk("sb_empty", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
